// File: rtl/lb_uart_rx_control_unit.sv
// ---------------------------------------------------------------------------
// lb_uart_rx_control_unit
//
// Control FSM for a UART receiver. It watches the (already synchronised)
// serial line for a start bit, confirms it at the half-bit point, then times
// each following bit with a run-time prescale. It pulses `shift` in the middle
// of every bit after the start bit, so a separate datapath shift register can
// sample `rx` on that cycle. Once the last frame bit (data, optional parity,
// stop) has been shifted, it pulses `done`. Data, parity and framing checks
// are left to the datapath.
//
// Ports:
//   clk           system clock, all state on the rising edge
//   reset         asynchronous active-low reset (0 = reset)
//   bit8          1 = 8 data bits, 0 = 7 data bits
//   parity_en     1 = a parity bit follows the data bits
//   baudPrescale  bit period minus one, in clk cycles (20 bits)
//   cs            synchronous abort back to IDLE, blocks shift/done
//   rx            serial line, idle high
//   done          one-cycle pulse: frame complete
//   shift         one-cycle pulse: datapath samples rx this cycle
// ---------------------------------------------------------------------------
module lb_uart_rx_control_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        bit8,
  input  logic        parity_en,
  input  logic [19:0] baudPrescale,
  input  logic        cs,
  input  logic        rx,
  output logic        done,
  output logic        shift
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [19:0] clk_cnt;
  logic [19:0] clk_cnt_next;
  logic [3:0]  bit_cnt;
  logic [3:0]  bit_cnt_next;
  logic [19:0] half_point;
  logic [3:0]  last_bit;

  // The start bit is re-checked at the half-bit point so that each later
  // sample lands one full period further on, i.e. mid-bit.
  assign half_point = baudPrescale >> 1;

  // Index of the final frame bit after the start bit: 7 or 8 data bits,
  // an optional parity bit, then the stop bit (frame length 8..10).
  assign last_bit = 4'd7 + {3'b000, bit8} + {3'b000, parity_en};

  // State and counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      clk_cnt <= '0;
      bit_cnt <= '0;
    end else begin
      state   <= state_next;
      clk_cnt <= clk_cnt_next;
      bit_cnt <= bit_cnt_next;
    end
  end

  // Next-state logic plus the shift/done decode. cs overrides everything,
  // which also keeps shift and done low in any cycle where cs is high.
  always_comb begin
    state_next   = state;
    clk_cnt_next = clk_cnt;
    bit_cnt_next = bit_cnt;
    shift        = 1'b0;
    done         = 1'b0;

    if (cs) begin
      state_next   = IDLE;
      clk_cnt_next = '0;
      bit_cnt_next = '0;
    end else begin
      case (state)
        IDLE: begin
          clk_cnt_next = '0;
          bit_cnt_next = '0;
          if (!rx) begin
            state_next = START;
          end
        end

        START: begin
          if (clk_cnt == half_point) begin
            clk_cnt_next = '0;
            bit_cnt_next = '0;
            // A line that is high again at mid start bit was a glitch.
            state_next   = rx ? IDLE : DATA;
          end else begin
            clk_cnt_next = clk_cnt + 20'd1;
          end
        end

        DATA: begin
          if (clk_cnt == baudPrescale) begin
            shift        = 1'b1;
            clk_cnt_next = '0;
            bit_cnt_next = bit_cnt + 4'd1;
            // The stop bit is shifted like any other bit; its value is
            // the datapath's business.
            if (bit_cnt == last_bit) begin
              state_next = DONE;
            end
          end else begin
            clk_cnt_next = clk_cnt + 20'd1;
          end
        end

        DONE: begin
          done         = 1'b1;
          clk_cnt_next = '0;
          bit_cnt_next = '0;
          state_next   = IDLE;
        end

        default: begin
          state_next   = IDLE;
          clk_cnt_next = '0;
          bit_cnt_next = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lb_uart_rx_control_unit.sv
// ---------------------------------------------------------------------------
// tb_lb_uart_rx_control_unit
//
// Scoreboard bench for the UART receive control FSM. Stimulus tasks drive
// serial frames and push every shift/done pulse they expect, with the clock
// cycle it must appear on, into a queue. An independent monitor pops one
// entry per pulse the DUT shows and compares kind, cycle and the rx level
// being sampled.
//
// Expected pulse times come from the frame timing rules: with the line
// falling in cycle t, period P and half point H, shift k (0-based) lands on
// cycle t+H+1+P*(k+1) and done one cycle after the last shift.
// ---------------------------------------------------------------------------
module tb_lb_uart_rx_control_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        bit8;
  logic        parity_en;
  logic [19:0] baudPrescale;
  logic        cs;
  logic        rx;
  logic        done;
  logic        shift;

  lb_uart_rx_control_unit dut (
    .clk          (clk),
    .reset        (reset),
    .bit8         (bit8),
    .parity_en    (parity_en),
    .baudPrescale (baudPrescale),
    .cs           (cs),
    .rx           (rx),
    .done         (done),
    .shift        (shift)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit is_done;
    int cyc;
    bit rx_val;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_pass   = 0;

  // Cycle index: value k holds from rising edge k to rising edge k+1.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Monitor: every pulse the DUT shows must match the head of the scoreboard.
  always @(negedge clk) begin
    if (shift || done) begin
      checkOutput("shift_done_overlap", int'(shift & done), 0);
      if (sb.size() == 0) begin
        checkOutput("unexpected_pulse", int'({shift, done}), 0);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("pulse_kind_done", int'(done), int'(mon_e.is_done));
        checkOutput("pulse_cycle", cyc, mon_e.cyc);
        if (!mon_e.is_done) begin
          checkOutput("shift_rx_value", int'(rx), int'(mon_e.rx_val));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Frame bits after the start bit, first-transmitted in bit 0.
  function automatic logic [9:0] mkBits(input logic [7:0] data, input logic b8,
                                        input logic pe, input logic par, input logic stop);
    logic [9:0] b;
    int nd;
    int idx;
    b  = '1;
    nd = b8 ? 8 : 7;
    for (int i = 0; i < nd; i++) b[i] = data[i];
    idx = nd;
    if (pe) begin
      b[idx] = par;
      idx++;
    end
    b[idx] = stop;
    return b;
  endfunction

  // Send one frame. abort_kind: 0 none, 1 cs pulse, 2 async reset; the abort
  // lands on the cycle where shift number abort_at would otherwise appear.
  task automatic applyStimulus(input logic b8, input logic pe, input int presc,
                               input logic [9:0] bits, input int abort_kind, input int abort_at);
    int n, p, h, t, last_shift, done_cyc, end_cyc, abort_cyc, o, j;
    exp_t e;
    n = 8 + int'(b8) + int'(pe);
    p = presc + 1;
    h = presc / 2;
    bit8         = b8;
    parity_en    = pe;
    baudPrescale = 20'(presc);
    t          = cyc;
    last_shift = t + h + 1 + p * n;
    done_cyc   = last_shift + 1;
    abort_cyc  = (abort_kind != 0) ? t + h + 1 + p * (abort_at + 1) : -1;
    for (int k = 0; k < n; k++) begin
      if (abort_kind != 0 && k >= abort_at) break;
      e.is_done = 1'b0;
      e.cyc     = t + h + 1 + p * (k + 1);
      e.rx_val  = bits[k];
      sb.push_back(e);
    end
    if (abort_kind == 0) begin
      e.is_done = 1'b1;
      e.cyc     = done_cyc;
      e.rx_val  = 1'b0;
      sb.push_back(e);
      end_cyc = done_cyc + 1;
    end else begin
      end_cyc = abort_cyc + 1;
    end
    while (cyc < end_cyc) begin
      o = cyc - t;
      // With P=1 the start confirmation uses one extra cycle, so the line is
      // held one clock later to keep each bit under its sample point.
      j = (p == 1) ? o - 1 : o / p;
      if (cyc > last_shift) rx = 1'b1;
      else if (j <= 0)      rx = 1'b0;
      else                  rx = bits[j-1];
      cs = (abort_kind == 1 && cyc == abort_cyc);
      if (abort_kind == 2 && cyc == abort_cyc) begin
        #1 reset = 1'b0;
        #1;
        checkOutput("async_reset_shift", int'(shift), 0);
        checkOutput("async_reset_done", int'(done), 0);
      end
      tick();
    end
    rx = 1'b1;
    cs = 1'b0;
    if (abort_kind == 2) begin
      tick();
      reset = 1'b1;
    end
  endtask

  // Hold the line low for len cycles: back-to-back frames restart while it
  // stays low at both the detect cycle and the half-bit confirmation.
  task automatic heldLow(input int presc, input logic b8, input logic pe, input int len);
    int n, p, h, t, s, c, d, end_cyc;
    exp_t e;
    n = 8 + int'(b8) + int'(pe);
    p = presc + 1;
    h = presc / 2;
    bit8         = b8;
    parity_en    = pe;
    baudPrescale = 20'(presc);
    t = cyc;
    s = t;
    while (s + h + 1 < t + len) begin
      for (int k = 0; k < n; k++) begin
        c = s + h + 1 + p * (k + 1);
        e.is_done = 1'b0;
        e.cyc     = c;
        e.rx_val  = (c < t + len) ? 1'b0 : 1'b1;
        sb.push_back(e);
      end
      d = s + h + 1 + p * n + 1;
      e.is_done = 1'b1;
      e.cyc     = d;
      e.rx_val  = 1'b0;
      sb.push_back(e);
      s = d + 1;
    end
    end_cyc = ((s > t + len) ? s : t + len) + h + 3;
    while (cyc < end_cyc) begin
      rx = (cyc < t + len) ? 1'b0 : 1'b1;
      tick();
    end
    rx = 1'b1;
  endtask

  task automatic falseStart(input int presc, input int low_len);
    int t;
    baudPrescale = 20'(presc);
    t = cyc;
    while (cyc < t + low_len) begin
      rx = 1'b0;
      tick();
    end
    rx = 1'b1;
    repeat (presc / 2 + 4) tick();
  endtask

  initial begin
    logic       rb8, rpe;
    int         rpresc, rsel, rat;
    logic [9:0] rbits;

    reset        = 1'b0;
    rx           = 1'b1;
    cs           = 1'b0;
    bit8         = 1'b1;
    parity_en    = 1'b0;
    baudPrescale = 20'd15;
    tick();
    tick();
    checkOutput("reset_shift", int'(shift), 0);
    checkOutput("reset_done", int'(done), 0);
    reset = 1'b1;
    repeat (20) tick();
    checkOutput("idle_no_pulses", sb.size(), 0);

    $display("[TB] minimum prescale, line held low");
    heldLow(0, 1'b1, 1'b1, 38);
    checkOutput("held_low_drain", sb.size(), 0);

    $display("[TB] prescale 15, frame 0x55");
    applyStimulus(1'b1, 1'b0, 15, mkBits(8'h55, 1'b1, 1'b0, 1'b0, 1'b1), 0, 0);
    checkOutput("frame55_drain", sb.size(), 0);

    $display("[TB] shortest and longest frames");
    applyStimulus(1'b0, 1'b0, 3, mkBits(8'h3A, 1'b0, 1'b0, 1'b0, 1'b1), 0, 0);
    applyStimulus(1'b1, 1'b1, 3, mkBits(8'hC6, 1'b1, 1'b1, 1'b1, 1'b1), 0, 0);
    checkOutput("length_drain", sb.size(), 0);

    $display("[TB] false start");
    falseStart(15, 4);
    checkOutput("false_start_quiet", sb.size(), 0);
    applyStimulus(1'b1, 1'b0, 15, mkBits(8'hA3, 1'b1, 1'b0, 1'b0, 1'b1), 0, 0);

    $display("[TB] cs abort and async reset mid-frame");
    applyStimulus(1'b1, 1'b0, 15, mkBits(8'h0F, 1'b1, 1'b0, 1'b0, 1'b1), 1, 3);
    repeat (3) tick();
    applyStimulus(1'b1, 1'b0, 15, mkBits(8'h96, 1'b1, 1'b0, 1'b0, 1'b0), 0, 0);
    applyStimulus(1'b1, 1'b1, 7, mkBits(8'h5C, 1'b1, 1'b1, 1'b0, 1'b1), 2, 5);
    repeat (20) tick();
    applyStimulus(1'b0, 1'b1, 7, mkBits(8'h21, 1'b0, 1'b1, 1'b1, 1'b1), 0, 0);
    checkOutput("abort_drain", sb.size(), 0);

    $display("[TB] randomized frames");
    repeat (16) begin
      rb8    = 1'($urandom_range(0, 1));
      rpe    = 1'($urandom_range(0, 1));
      rpresc = int'($urandom_range(0, 20));
      rbits  = mkBits(8'($urandom), rb8, rpe, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      rsel   = int'($urandom_range(0, 5));
      rat    = int'($urandom_range(0, 7));
      if (rsel == 0)      applyStimulus(rb8, rpe, rpresc, rbits, 1, rat);
      else if (rsel == 1) applyStimulus(rb8, rpe, rpresc, rbits, 2, rat);
      else                applyStimulus(rb8, rpe, rpresc, rbits, 0, 0);
      repeat ($urandom_range(0, 3)) tick();
    end
    repeat (5) tick();
    checkOutput("final_drain", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
